ins_cache_ctrl: RTL

Instruction cache that answers the program counter's `addr_ins` requests. It holds one block of ISA_DEPTH instructions in on-chip RAM and refills from DDR when the requested address falls outside the cached block. It reports `ins_cache_rdy`, `st_cur_ins_cache` and `load_times` back to the program counter, and drives the fetched instruction with a valid pulse toward AP_ctrl.

---
 rtl/ins_cache_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ins_cache_ctrl.sv
// Single-block instruction cache: serves program-counter fetches from on-chip RAM
// and refills a whole ISA_DEPTH block from DDR whenever the PC leaves that block.
module ins_cache_ctrl #(
    parameter int ADDR_WIDTH_MEM  = 16,
    parameter int ISA_DEPTH       = 64,
    parameter int TOTAL_ISA_DEPTH = 128,
    parameter int DDR_ADDR_WIDTH  = 28,
    parameter int ISA_WIDTH       = 32,
    parameter logic [DDR_ADDR_WIDTH-1:0] DDR_BASE_ISA = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    output logic [ISA_WIDTH-1:0]      ins_out,
    output logic                      ins_valid,
    output logic                      ins_cache_rdy,
    output logic [3:0]                st_cur_ins_cache,
    output logic [9:0]                load_times,
    output logic                      ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    input  logic                      ddr_rd_ack,
    input  logic [ISA_WIDTH-1:0]      ddr_rd_data,
    input  logic                      ddr_rd_data_valid
);
    localparam int IDX_W = $clog2(ISA_DEPTH);
    localparam int BLK_W = ADDR_WIDTH_MEM - 1 - IDX_W;
    localparam int LT_W  = 10;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_REQ  = 4'd1,
        LOAD_DATA = 4'd2,
        SENT_INS  = 4'd3,
        FINISH    = 4'd4
    } state_t;

    state_t state_reg, state_next;

    logic [ISA_WIDTH-1:0]      ram [ISA_DEPTH];
    logic [IDX_W-1:0]          cnt_reg;
    logic [BLK_W-1:0]          blk_reg;
    logic [LT_W-1:0]           load_times_reg;
    logic [ADDR_WIDTH_MEM-1:0] addr_prev_reg;
    logic                      entry_reg;
    logic [ISA_WIDTH-1:0]      ins_out_reg;
    logic                      ins_valid_reg;
    logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr_reg;

    logic [BLK_W-1:0] blk_cur;
    logic [IDX_W-1:0] idx_cur;
    logic             jump_c, end_c, hit_c, miss_c;
    logic             last_word, fire, rdy_next;

    // Address classification, evaluated every cycle on the live PC address
    always_comb begin
        blk_cur = addr_ins[ADDR_WIDTH_MEM-2:IDX_W];
        idx_cur = addr_ins[IDX_W-1:0];
        jump_c  = addr_ins[ADDR_WIDTH_MEM-1];
        end_c   = !jump_c && (addr_ins >= ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH));
        hit_c   = !jump_c && !end_c && (load_times_reg != '0)
                  && (LT_W'(blk_cur) == load_times_reg - LT_W'(1));
        miss_c  = !jump_c && !end_c && !hit_c;
    end

    assign last_word = (state_reg == LOAD_DATA) && ddr_rd_data_valid
                       && (cnt_reg == IDX_W'(ISA_DEPTH - 1));

    // Fetch on block entry, or when the PC moves to another address inside the block
    assign fire = (state_reg == SENT_INS) && hit_c
                  && (entry_reg || (addr_ins != addr_prev_reg));

    always_comb begin
        state_next = state_reg;
        rdy_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (hit_c)       state_next = SENT_INS;
                else if (miss_c) state_next = LOAD_REQ;
                else if (end_c)  state_next = FINISH;
            end
            LOAD_REQ: begin
                if (ddr_rd_ack) state_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (last_word) state_next = SENT_INS;
            end
            SENT_INS: begin
                rdy_next = !miss_c;
                if (miss_c)     state_next = LOAD_REQ;
                else if (end_c) state_next = FINISH;
            end
            FINISH: begin
                rdy_next = 1'b1;
                if (hit_c)       state_next = SENT_INS;
                else if (miss_c) state_next = LOAD_REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            blk_reg         <= '0;
            load_times_reg  <= '0;
            addr_prev_reg   <= '0;
            entry_reg       <= 1'b0;
            ins_out_reg     <= '0;
            ins_valid_reg   <= 1'b0;
            ddr_rd_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_prev_reg <= addr_ins;
            entry_reg     <= (state_next == SENT_INS) && (state_reg != SENT_INS);
            ins_valid_reg <= fire;
            if (fire)
                ins_out_reg <= ram[idx_cur];
            // Block index and burst address are frozen for the whole refill
            if ((state_next == LOAD_REQ) && (state_reg != LOAD_REQ)) begin
                blk_reg         <= blk_cur;
                ddr_rd_addr_reg <= DDR_BASE_ISA + (DDR_ADDR_WIDTH'(blk_cur) << (IDX_W + 3));
            end
            if ((state_reg == LOAD_DATA) && ddr_rd_data_valid)
                cnt_reg <= cnt_reg + IDX_W'(1);
            if (last_word)
                load_times_reg <= LT_W'(blk_reg) + LT_W'(1);
        end
    end

    // RAM contents survive reset; load_times alone marks them valid
    always_ff @(posedge clk) begin
        if ((state_reg == LOAD_DATA) && ddr_rd_data_valid)
            ram[cnt_reg] <= ddr_rd_data;
    end

    assign ins_out          = ins_out_reg;
    assign ins_valid        = ins_valid_reg;
    assign ins_cache_rdy    = rdy_next;
    assign st_cur_ins_cache = state_reg;
    assign load_times       = load_times_reg;
    assign ddr_rd_req       = (state_reg == LOAD_REQ);
    assign ddr_rd_addr      = ddr_rd_addr_reg;

endmodule
